// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback stage.
//   REG_ID_W   width of a register id (64 entries: x0-x31 = 0-31, f0-f31 = 32-63)
//   REG_ZERO   the hard-wired zero register x0
//   wb_state_e post-reset clear sequence / normal operation
//   wb_src_e   where a decode read port takes its data from
//   wb_trace_t one retire-trace record
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int REG_ID_W = 6;
  localparam logic [REG_ID_W-1:0] REG_ZERO = 6'd0;

  // Width of the trace data field; matches the default register width.
  localparam int WB_XLEN = 32;

  typedef enum logic {
    WB_CLEAR = 1'b0,
    WB_RUN   = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RF   = 2'd1,
    SRC_BYP  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [REG_ID_W-1:0] rd;
    logic [WB_XLEN-1:0]  data;
  } wb_trace_t;

  // Picks the source for a read port: x0 always reads zero, a read of the
  // register being committed this cycle takes the new data (write-first),
  // anything else comes from the array.
  function automatic wb_src_e read_src(input logic [REG_ID_W-1:0] rs,
                                       input logic                we,
                                       input logic [REG_ID_W-1:0] rd);
    if (rs == REG_ZERO) begin
      return SRC_ZERO;
    end
    if (we && (rs == rd)) begin
      return SRC_BYP;
    end
    return SRC_RF;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Bundle between the memory stage / decode stage and the writeback unit.
//   MW_*     bundle registered by the memory stage (PC, instr, nop, rdId,
//            wbData, wbEnable)
//   D_*      decode read request (readEn, rs1Id, rs2Id, rs3Id)
//   DE_*     read data returned to decode, one cycle after the address
//   W_*      registered commit for execute-stage forwarding
//   rfReady  low while the register file is being cleared
//   instret  64-bit retired-instruction count
//   tr*      retire trace record (active only with WB_RETIRE_TRACE_EN)
// Modports: slave = writeback unit, master = surrounding pipeline.
// ---------------------------------------------------------------------------
interface writeback_unit_if
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic [31:0]         MW_PC;
  logic [31:0]         MW_instr;
  logic                MW_nop;
  logic [REG_ID_W-1:0] MW_rdId;
  logic [XLEN-1:0]     MW_wbData;
  logic                MW_wbEnable;

  logic                D_readEn;
  logic [REG_ID_W-1:0] D_rs1Id;
  logic [REG_ID_W-1:0] D_rs2Id;
  logic [REG_ID_W-1:0] D_rs3Id;

  logic [XLEN-1:0]     DE_rs1;
  logic [XLEN-1:0]     DE_rs2;
  logic [XLEN-1:0]     DE_rs3;

  logic [REG_ID_W-1:0] W_rdId;
  logic [XLEN-1:0]     W_wbData;
  logic                W_wbEnable;

  logic                rfReady;
  logic [63:0]         instret;

  logic                trValid;
  logic [31:0]         trPC;
  logic [31:0]         trInstr;
  logic [XLEN-1:0]     trData;
  logic [REG_ID_W-1:0] trRd;

  modport slave (
    input  MW_PC, MW_instr, MW_nop, MW_rdId, MW_wbData, MW_wbEnable,
    input  D_readEn, D_rs1Id, D_rs2Id, D_rs3Id,
    output DE_rs1, DE_rs2, DE_rs3,
    output W_rdId, W_wbData, W_wbEnable,
    output rfReady, instret,
    output trValid, trPC, trInstr, trData, trRd
  );

  modport master (
    output MW_PC, MW_instr, MW_nop, MW_rdId, MW_wbData, MW_wbEnable,
    output D_readEn, D_rs1Id, D_rs2Id, D_rs3Id,
    input  DE_rs1, DE_rs2, DE_rs3,
    input  W_rdId, W_wbData, W_wbEnable,
    input  rfReady, instret,
    input  trValid, trPC, trInstr, trData, trRd
  );

endinterface

// File: rtl/regfile_1w3r.sv
// ---------------------------------------------------------------------------
// regfile_1w3r
// NUM_REGS x XLEN register array with one write port and three registered
// read ports sharing one read enable. The array has no reset so it maps onto
// block RAM; clearing is done by the owner through the write port. A read of
// an address written on the same edge returns the old contents; the owner
// adds bypass where write-first behaviour is needed.
//   clk_i               clock
//   we_i, waddr_i, wdata_i      write port
//   re_i                read enable; read data holds while low
//   raddr{1,2,3}_i      read addresses
//   rdata{1,2,3}_o      registered read data
// ---------------------------------------------------------------------------
module regfile_1w3r
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 64
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [REG_ID_W-1:0] waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic                re_i,
  input  logic [REG_ID_W-1:0] raddr1_i,
  input  logic [REG_ID_W-1:0] raddr2_i,
  input  logic [REG_ID_W-1:0] raddr3_i,
  output logic [XLEN-1:0]     rdata1_o,
  output logic [XLEN-1:0]     rdata2_o,
  output logic [XLEN-1:0]     rdata3_o
);

  logic [XLEN-1:0] mem [NUM_REGS];

  // Single write port into the array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read ports; holding while re_i is low keeps a stalled
  // decode's operands stable.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata1_o <= mem[raddr1_i];
      rdata2_o <= mem[raddr2_i];
      rdata3_o <= mem[raddr3_i];
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Final pipeline stage. Commits the MW bundle into the 64-entry register
// file, serves decode's three synchronous read ports with write-first bypass,
// forwards the registered commit to execute and counts retired instructions.
// After reset it zeroes every register entry (one per cycle) and holds
// rfReady low until done; MW writes and reads are ignored meanwhile.
// Ports:
//   clk_i     clock, rising edge
//   reset_i   synchronous active-high reset; restarts the clear sequence
//   wb        writeback_unit_if.slave (MW bundle, decode reads, commit,
//             rfReady, instret, trace)
// Configuration macro:
//   WB_RETIRE_TRACE_EN  when defined, registers one trace record per retired
//                       instruction; otherwise the trace outputs are tied 0.
// ---------------------------------------------------------------------------
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  writeback_unit_if.slave    wb
);

  localparam logic [REG_ID_W-1:0] LAST_IDX = REG_ID_W'(NUM_REGS - 1);

  wb_state_e           state_q, state_d;
  logic [REG_ID_W-1:0] clear_idx_q, clear_idx_d;
  logic                running;
  logic                clearing;
  logic                we;
  logic                retire;

  logic                rf_we;
  logic [REG_ID_W-1:0] rf_waddr;
  logic [XLEN-1:0]     rf_wdata;
  logic                rf_re;
  logic [XLEN-1:0]     rf_rdata [3];

  logic [REG_ID_W-1:0] rs_id    [3];
  wb_src_e             src_q    [3];
  logic [XLEN-1:0]     byp_q    [3];
  logic [XLEN-1:0]     de_data  [3];

  logic [REG_ID_W-1:0] w_rd_id_q;
  logic [XLEN-1:0]     w_wb_data_q;
  logic                w_wb_enable_q;
  logic [63:0]         instret_q;

  assign running  = (state_q == WB_RUN);
  assign clearing = (state_q == WB_CLEAR);

  // A commit only counts when running, enabled, not a bubble and not x0.
  assign we     = running & wb.MW_wbEnable & ~wb.MW_nop & (wb.MW_rdId != REG_ZERO);
  assign retire = running & ~wb.MW_nop;

  // State register for the clear sequence; reset always restarts it at 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= WB_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  // Walk every entry once, then switch to normal operation on the edge that
  // writes the last entry.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    unique case (state_q)
      WB_CLEAR: begin
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == LAST_IDX) begin
          state_d = WB_RUN;
        end
      end
      WB_RUN: begin
        clear_idx_d = '0;
      end
      default: begin
        state_d     = WB_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  // The single write port is shared between the clear walk and commits.
  always_comb begin
    rf_we    = we;
    rf_waddr = wb.MW_rdId;
    rf_wdata = wb.MW_wbData;
    if (clearing) begin
      rf_we    = 1'b1;
      rf_waddr = clear_idx_q;
      rf_wdata = '0;
    end
  end

  assign rf_re    = running & wb.D_readEn;
  assign rs_id[0] = wb.D_rs1Id;
  assign rs_id[1] = wb.D_rs2Id;
  assign rs_id[2] = wb.D_rs3Id;

  regfile_1w3r #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk_i    (clk_i),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .re_i     (rf_re),
    .raddr1_i (rs_id[0]),
    .raddr2_i (rs_id[1]),
    .raddr3_i (rs_id[2]),
    .rdata1_o (rf_rdata[0]),
    .rdata2_o (rf_rdata[1]),
    .rdata3_o (rf_rdata[2])
  );

  // The array read is registered inside the regfile, so the bypass decision
  // is registered alongside it and applied after the array output. The
  // select and bypass data hold with the array output while decode stalls,
  // and are forced to zero during the clear walk.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 3; i++) begin
        src_q[i] <= SRC_ZERO;
        byp_q[i] <= '0;
      end
    end else if (!running) begin
      for (int i = 0; i < 3; i++) begin
        src_q[i] <= SRC_ZERO;
      end
    end else if (wb.D_readEn) begin
      for (int i = 0; i < 3; i++) begin
        src_q[i] <= read_src(rs_id[i], we, wb.MW_rdId);
        byp_q[i] <= wb.MW_wbData;
      end
    end
  end

  // Final read-data mux per port.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      de_data[i] = '0;
      unique case (src_q[i])
        SRC_RF:   de_data[i] = rf_rdata[i];
        SRC_BYP:  de_data[i] = byp_q[i];
        default:  de_data[i] = '0;
      endcase
    end
  end

  assign wb.DE_rs1 = de_data[0];
  assign wb.DE_rs2 = de_data[1];
  assign wb.DE_rs3 = de_data[2];

  // Registered commit for execute-stage forwarding; the strobe carries only
  // effective writes so execute never forwards a dropped or x0 write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_rd_id_q     <= '0;
      w_wb_data_q   <= '0;
      w_wb_enable_q <= 1'b0;
    end else begin
      w_rd_id_q     <= wb.MW_rdId;
      w_wb_data_q   <= wb.MW_wbData;
      w_wb_enable_q <= we;
    end
  end

  assign wb.W_rdId     = w_rd_id_q;
  assign wb.W_wbData   = w_wb_data_q;
  assign wb.W_wbEnable = w_wb_enable_q;
  assign wb.rfReady    = running;

  // Every non-bubble instruction retires, whether or not it writes; the
  // counter wraps naturally at 2^64.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb.instret = instret_q;

`ifdef WB_RETIRE_TRACE_EN
  logic      tr_valid_q;
  wb_trace_t tr_q;

  // One trace record per retire; rd/data report only effective writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tr_valid_q <= 1'b0;
      tr_q       <= '0;
    end else begin
      tr_valid_q <= retire;
      if (retire) begin
        tr_q.pc    <= wb.MW_PC;
        tr_q.instr <= wb.MW_instr;
        tr_q.rd    <= we ? wb.MW_rdId : REG_ZERO;
        tr_q.data  <= we ? WB_XLEN'(wb.MW_wbData) : '0;
      end
    end
  end

  assign wb.trValid = tr_valid_q;
  assign wb.trPC    = tr_q.pc;
  assign wb.trInstr = tr_q.instr;
  assign wb.trRd    = tr_q.rd;
  assign wb.trData  = XLEN'(tr_q.data);
`else
  // PC and instruction word only feed the trace; nothing else consumes them.
  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{wb.MW_PC, wb.MW_instr};

  assign wb.trValid = 1'b0;
  assign wb.trPC    = '0;
  assign wb.trInstr = '0;
  assign wb.trRd    = '0;
  assign wb.trData  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
// Directed bench for writeback_unit: clear sequence, commit/read, bypass,
// x0 handling, FP register, read stall hold, retire counter with wrap,
// trace record (when WB_RETIRE_TRACE_EN is defined) and reset during clear.
// ---------------------------------------------------------------------------
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int XLEN = 32;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  writeback_unit_if #(.XLEN(XLEN)) wbi ();

  writeback_unit #(
    .XLEN     (XLEN),
    .NUM_REGS (64)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wb       (wbi)
  );

  // 10 time-unit clock.
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bubble();
    wbi.MW_PC       = 32'h0;
    wbi.MW_instr    = 32'h0;
    wbi.MW_nop      = 1'b1;
    wbi.MW_rdId     = 6'd0;
    wbi.MW_wbData   = '0;
    wbi.MW_wbEnable = 1'b0;
  endtask

  task automatic drive_retire(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [5:0] rd, input logic [XLEN-1:0] data,
                              input logic en);
    wbi.MW_PC       = pc;
    wbi.MW_instr    = instr;
    wbi.MW_nop      = 1'b0;
    wbi.MW_rdId     = rd;
    wbi.MW_wbData   = data;
    wbi.MW_wbEnable = en;
  endtask

  task automatic drive_read(input logic en, input logic [5:0] r1,
                            input logic [5:0] r2, input logic [5:0] r3);
    wbi.D_readEn = en;
    wbi.D_rs1Id  = r1;
    wbi.D_rs2Id  = r2;
    wbi.D_rs3Id  = r3;
  endtask

  task automatic test_reset();
    int n;
    logic any_nonzero;
    reset_i = 1'b1;
    drive_bubble();
    drive_read(1'b0, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    tests_run++; if (wbi.rfReady !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rfReady: got %b expected 0", wbi.rfReady); end
    tests_run++; if (wbi.instret !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_instret: got %h expected 0", wbi.instret); end
    tests_run++; if (wbi.DE_rs1 !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_DE_rs1: got %h expected 0", wbi.DE_rs1); end
    tests_run++; if (wbi.W_wbEnable !== 1'b0 || wbi.W_rdId !== 6'd0 || wbi.W_wbData !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_W: got en=%b id=%0d data=%h expected all 0", wbi.W_wbEnable, wbi.W_rdId, wbi.W_wbData); end
    tests_run++; if (wbi.trValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_trValid: got %b expected 0", wbi.trValid); end

    // Release reset and count clear cycles; a write to x2 and a retire
    // in the middle of the clear must both be ignored.
    reset_i = 1'b0;
    n = 0;
    while (wbi.rfReady !== 1'b1 && n < 200) begin
      if (n == 10) drive_retire(32'h40, 32'h13, 6'd2, 32'h55, 1'b1);
      else         drive_bubble();
      tick();
      n++;
    end
    tests_run++; if (n != 64) begin tests_failed++; $display("[TB] FAIL clear_cycles: got %0d expected 64", n); end
    drive_bubble();
    tests_run++; if (wbi.instret !== 64'd0) begin tests_failed++; $display("[TB] FAIL clear_no_retire: got %h expected 0", wbi.instret); end

    any_nonzero = 1'b0;
    for (int i = 1; i < 64; i++) begin
      drive_read(1'b1, 6'(i), 6'(i), 6'(i));
      tick();
      tests_run++;
      if (wbi.DE_rs1 !== 32'd0 || wbi.DE_rs2 !== 32'd0 || wbi.DE_rs3 !== 32'd0) begin
        tests_failed++;
        any_nonzero = 1'b1;
        $display("[TB] FAIL clear_read id=%0d: got %h/%h/%h expected 0", i, wbi.DE_rs1, wbi.DE_rs2, wbi.DE_rs3);
      end
    end
    if (!any_nonzero) $display("[TB] ids 1..63 read zero after clear");
  endtask

  task automatic test_commit();
    drive_read(1'b1, 6'd0, 6'd0, 6'd0);
    drive_retire(32'h10, 32'h0, 6'd5, 32'hDEADBEEF, 1'b1);
    tick();
    tests_run++; if (wbi.W_rdId !== 6'd5 || wbi.W_wbData !== 32'hDEADBEEF || wbi.W_wbEnable !== 1'b1) begin tests_failed++; $display("[TB] FAIL commit_W: got id=%0d data=%h en=%b expected 5/deadbeef/1", wbi.W_rdId, wbi.W_wbData, wbi.W_wbEnable); end
    drive_bubble();
    drive_read(1'b1, 6'd5, 6'd0, 6'd0);
    tick();
    tests_run++; if (wbi.DE_rs1 !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL commit_read: got %h expected deadbeef", wbi.DE_rs1); end
    tests_run++; if (wbi.W_wbEnable !== 1'b0) begin tests_failed++; $display("[TB] FAIL bubble_W_en: got %b expected 0", wbi.W_wbEnable); end
  endtask

  task automatic test_bypass();
    drive_retire(32'h14, 32'h0, 6'd7, 32'h1234, 1'b1);
    drive_read(1'b1, 6'd0, 6'd7, 6'd0);
    tick();
    tests_run++; if (wbi.DE_rs2 !== 32'h1234) begin tests_failed++; $display("[TB] FAIL bypass_rs2: got %h expected 00001234", wbi.DE_rs2); end

    drive_retire(32'h18, 32'h0, 6'd0, 32'hFF, 1'b1);
    drive_read(1'b1, 6'd0, 6'd0, 6'd0);
    tick();
    tests_run++; if (wbi.DE_rs1 !== 32'd0) begin tests_failed++; $display("[TB] FAIL x0_read: got %h expected 0", wbi.DE_rs1); end
    tests_run++; if (wbi.W_wbEnable !== 1'b0) begin tests_failed++; $display("[TB] FAIL x0_W_en: got %b expected 0", wbi.W_wbEnable); end

    // A bubble carrying wbEnable must neither write nor bypass.
    wbi.MW_PC = 32'h1C; wbi.MW_instr = 32'h0; wbi.MW_nop = 1'b1;
    wbi.MW_rdId = 6'd7; wbi.MW_wbData = 32'h9999; wbi.MW_wbEnable = 1'b1;
    drive_read(1'b1, 6'd0, 6'd7, 6'd0);
    tick();
    tests_run++; if (wbi.DE_rs2 !== 32'h1234) begin tests_failed++; $display("[TB] FAIL nop_no_bypass: got %h expected 00001234", wbi.DE_rs2); end
    drive_bubble();
    tick();
    tests_run++; if (wbi.DE_rs2 !== 32'h1234) begin tests_failed++; $display("[TB] FAIL nop_no_write: got %h expected 00001234", wbi.DE_rs2); end
  endtask

  task automatic test_fp_hold();
    drive_read(1'b1, 6'd0, 6'd0, 6'd0);
    drive_retire(32'h20, 32'h0, 6'd32, 32'hA5A5A5A5, 1'b1);
    tick();
    drive_bubble();
    drive_read(1'b1, 6'd0, 6'd0, 6'd32);
    tick();
    tests_run++; if (wbi.DE_rs3 !== 32'hA5A5A5A5) begin tests_failed++; $display("[TB] FAIL f0_read: got %h expected a5a5a5a5", wbi.DE_rs3); end

    drive_read(1'b0, 6'd0, 6'd0, 6'd32);
    drive_retire(32'h24, 32'h0, 6'd32, 32'h1, 1'b1);
    tick();
    tests_run++; if (wbi.DE_rs3 !== 32'hA5A5A5A5) begin tests_failed++; $display("[TB] FAIL stall_hold: got %h expected a5a5a5a5", wbi.DE_rs3); end
    drive_bubble();
    tick();
    tests_run++; if (wbi.DE_rs3 !== 32'hA5A5A5A5) begin tests_failed++; $display("[TB] FAIL stall_hold2: got %h expected a5a5a5a5", wbi.DE_rs3); end
    drive_read(1'b1, 6'd0, 6'd0, 6'd32);
    tick();
    tests_run++; if (wbi.DE_rs3 !== 32'h1) begin tests_failed++; $display("[TB] FAIL stall_release: got %h expected 00000001", wbi.DE_rs3); end
  endtask

  task automatic test_instret();
    // Retires so far: x5, x7, x0 and two writes to f0.
    drive_read(1'b0, 6'd0, 6'd0, 6'd0);
    tests_run++; if (wbi.instret !== 64'd5) begin tests_failed++; $display("[TB] FAIL instret_start: got %0d expected 5", wbi.instret); end
    for (int i = 0; i < 15; i++) begin
      if (i < 10)      drive_retire(32'h100 + 32'(i * 4), 32'h0, 6'(10 + i), 32'(i), 1'b1);
      else if (i < 13) drive_bubble();
      else             drive_retire(32'h200 + 32'(i * 4), 32'h0, 6'd3, 32'hBAD, 1'b0);
      tick();
    end
    tests_run++; if (wbi.W_wbEnable !== 1'b0) begin tests_failed++; $display("[TB] FAIL noen_W_en: got %b expected 0", wbi.W_wbEnable); end
    drive_bubble();
    tests_run++; if (wbi.instret !== 64'd17) begin tests_failed++; $display("[TB] FAIL instret_count: got %0d expected 17", wbi.instret); end

    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    drive_retire(32'h300, 32'h0, 6'd0, 32'h0, 1'b0);
    tick();
    tests_run++; if (wbi.instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("[TB] FAIL instret_max: got %h expected ffffffffffffffff", wbi.instret); end
    tick();
    tests_run++; if (wbi.instret !== 64'd0) begin tests_failed++; $display("[TB] FAIL instret_wrap: got %h expected 0", wbi.instret); end
    drive_bubble();
    tick();
    tests_run++; if (wbi.instret !== 64'd0) begin tests_failed++; $display("[TB] FAIL instret_bubble: got %h expected 0", wbi.instret); end
  endtask

  task automatic test_trace();
    drive_retire(32'h100, 32'h00000013, 6'd3, 32'h77, 1'b1);
    tick();
`ifdef WB_RETIRE_TRACE_EN
    tests_run++; if (wbi.trValid !== 1'b1 || wbi.trPC !== 32'h100) begin tests_failed++; $display("[TB] FAIL trace_pc: got v=%b pc=%h expected 1/00000100", wbi.trValid, wbi.trPC); end
    tests_run++; if (wbi.trInstr !== 32'h13 || wbi.trRd !== 6'd3 || wbi.trData !== 32'h77) begin tests_failed++; $display("[TB] FAIL trace_fields: got instr=%h rd=%0d data=%h expected 13/3/77", wbi.trInstr, wbi.trRd, wbi.trData); end
    drive_retire(32'h104, 32'h00000033, 6'd4, 32'h88, 1'b0);
    tick();
    tests_run++; if (wbi.trValid !== 1'b1 || wbi.trPC !== 32'h104 || wbi.trRd !== 6'd0 || wbi.trData !== 32'd0) begin tests_failed++; $display("[TB] FAIL trace_nowrite: got v=%b pc=%h rd=%0d data=%h expected 1/104/0/0", wbi.trValid, wbi.trPC, wbi.trRd, wbi.trData); end
    drive_bubble();
    tick();
    tests_run++; if (wbi.trValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL trace_bubble: got %b expected 0", wbi.trValid); end
`else
    tests_run++; if (wbi.trValid !== 1'b0 || wbi.trPC !== 32'd0 || wbi.trData !== 32'd0 || wbi.trRd !== 6'd0) begin tests_failed++; $display("[TB] FAIL trace_tied: got v=%b pc=%h rd=%0d data=%h expected 0", wbi.trValid, wbi.trPC, wbi.trRd, wbi.trData); end
    drive_bubble();
`endif
  endtask

  task automatic test_reset_midclear();
    int n;
    drive_bubble();
    drive_read(1'b0, 6'd0, 6'd0, 6'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    repeat (20) tick();
    tests_run++; if (wbi.rfReady !== 1'b0) begin tests_failed++; $display("[TB] FAIL midclear_ready: got %b expected 0", wbi.rfReady); end
    reset_i = 1'b1;
    tick();
    tests_run++; if (wbi.rfReady !== 1'b0 || wbi.instret !== 64'd0) begin tests_failed++; $display("[TB] FAIL midclear_reset: got ready=%b instret=%h expected 0/0", wbi.rfReady, wbi.instret); end
    reset_i = 1'b0;
    n = 0;
    while (wbi.rfReady !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests_run++; if (n != 64) begin tests_failed++; $display("[TB] FAIL restart_cycles: got %0d expected 64", n); end
    drive_read(1'b1, 6'd5, 6'd7, 6'd32);
    tick();
    tests_run++; if (wbi.DE_rs1 !== 32'd0 || wbi.DE_rs2 !== 32'd0 || wbi.DE_rs3 !== 32'd0) begin tests_failed++; $display("[TB] FAIL restart_cleared: got %h/%h/%h expected 0", wbi.DE_rs1, wbi.DE_rs2, wbi.DE_rs3); end
  endtask

  initial begin
    drive_bubble();
    drive_read(1'b0, 6'd0, 6'd0, 6'd0);
    test_reset();
    test_commit();
    test_bypass();
    test_fp_hold();
    test_instret();
    test_trace();
    test_reset_midclear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
